// File: rtl/snax_hwpe_periph_arbiter_if.sv
// Shared HWPE peripheral register port: one request channel plus a read-response channel.
interface hwpe_ctrl_intf_periph #(
   parameter int unsigned IdWidth = 5
);
   logic               req;
   logic               gnt;
   logic [31:0]        add;
   logic               wen;
   logic [3:0]         be;
   logic [31:0]        data;
   logic [IdWidth-1:0] id;
   logic               r_valid;
   logic [31:0]        r_data;
   logic [IdWidth-1:0] r_id;

   modport master (
      output req, add, wen, be, data, id,
      input  gnt, r_valid, r_data, r_id
   );

   modport slave (
      input  req, add, wen, be, data, id,
      output gnt, r_valid, r_data, r_id
   );
endinterface

// File: rtl/snax_hwpe_periph_arbiter.sv
// Round-robin arbiter funnelling NumReq requesters onto one HWPE peripheral port,
// one transaction in flight; read data is routed back to the owning requester.
module snax_hwpe_periph_arbiter_resp_lane #(
   parameter int unsigned IdWidth = 5
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               i_cap,
   input  logic               i_clr,
   input  logic [31:0]        i_data,
   input  logic [IdWidth-1:0] i_id,
   output logic               o_valid,
   output logic [31:0]        o_data,
   output logic [IdWidth-1:0] o_id
);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_id    <= '0;
      end else if (i_cap) begin
         o_valid <= 1'b1;
         o_data  <= i_data;
         o_id    <= i_id;
      end else if (i_clr) begin
         o_valid <= 1'b0;
      end
   end
endmodule

module snax_hwpe_periph_arbiter #(
   parameter int unsigned NumReq  = 2,
   parameter int unsigned IdWidth = 5
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NumReq-1:0]                req_valid_i,
   output logic [NumReq-1:0]                req_ready_o,
   input  logic [NumReq-1:0][31:0]          req_add_i,
   input  logic [NumReq-1:0]                req_wen_i,
   input  logic [NumReq-1:0][31:0]          req_data_i,
   input  logic [NumReq-1:0][IdWidth-1:0]   req_id_i,
   output logic [NumReq-1:0]                resp_valid_o,
   input  logic [NumReq-1:0]                resp_ready_i,
   output logic [NumReq-1:0][31:0]          resp_data_o,
   output logic [NumReq-1:0][IdWidth-1:0]   resp_id_o,
   hwpe_ctrl_intf_periph.master             periph,
   output logic                             busy_o
);
   localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] WAIT_R = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]         r_state;
   logic [PtrW-1:0]    r_ptr;
   logic [PtrW-1:0]    r_owner;
   logic [31:0]        r_add;
   logic               r_wen;
   logic [3:0]         r_be;
   logic [31:0]        r_data;
   logic [IdWidth-1:0] r_id;

   logic [PtrW-1:0]    w_win;
   logic               w_any;
   logic               w_accept;
   logic [PtrW-1:0]    w_next_ptr;
   logic [NumReq-1:0]  w_cap;
   logic [NumReq-1:0]  w_clr;

   // Scan offsets from the far end so the nearest valid index at/after r_ptr wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         int unsigned idx;
         idx = int'(r_ptr) + i;
         if (idx >= NumReq) idx = idx - NumReq;
         if (req_valid_i[idx]) begin
            w_any = 1'b1;
            w_win = PtrW'(idx);
         end
      end
   end

   // Gated by rst_ni so ready is forced low while reset is held.
   assign w_accept   = rst_ni && (r_state == IDLE) && w_any;
   assign w_next_ptr = (r_owner == PtrW'(NumReq - 1)) ? '0 : r_owner + 1'b1;

   always_comb begin
      req_ready_o = '0;
      if (w_accept) req_ready_o[w_win] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_add   <= '0;
         r_wen   <= 1'b0;
         r_be    <= '0;
         r_data  <= '0;
         r_id    <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_state <= ISSUE;
               r_owner <= w_win;
               r_add   <= req_add_i[w_win];
               r_wen   <= req_wen_i[w_win];
               r_be    <= req_wen_i[w_win] ? 4'h0 : 4'hF;
               r_data  <= req_data_i[w_win];
               r_id    <= req_id_i[w_win];
            end
            ISSUE: if (periph.gnt) begin
               if (r_wen) begin
                  r_state <= WAIT_R;
               end else begin
                  r_state <= IDLE;
                  r_ptr   <= w_next_ptr;
               end
            end
            WAIT_R: if (periph.r_valid) r_state <= RESP;
            RESP: if (resp_ready_i[r_owner]) begin
               r_state <= IDLE;
               r_ptr   <= w_next_ptr;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign periph.req  = (r_state == ISSUE);
   assign periph.add  = r_add;
   assign periph.wen  = r_wen;
   assign periph.be   = r_be;
   assign periph.data = r_data;
   assign periph.id   = r_id;
   assign busy_o      = (r_state != IDLE);

   for (genvar g = 0; g < NumReq; g++) begin : g_lane
      assign w_cap[g] = (r_state == WAIT_R) && periph.r_valid && (r_owner == PtrW'(g));
      assign w_clr[g] = (r_state == RESP) && resp_ready_i[g] && (r_owner == PtrW'(g));

      snax_hwpe_periph_arbiter_resp_lane #(.IdWidth(IdWidth)) i_lane (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .i_cap   (w_cap[g]),
         .i_clr   (w_clr[g]),
         .i_data  (periph.r_data),
         .i_id    (periph.r_id),
         .o_valid (resp_valid_o[g]),
         .o_data  (resp_data_o[g]),
         .o_id    (resp_id_o[g])
      );
   end
endmodule

// File: tb/tb_snax_hwpe_periph_arbiter.sv
// Randomized bench for snax_hwpe_periph_arbiter against a transaction-level round-robin model.
module tb_snax_hwpe_periph_arbiter;
   localparam int N  = 3;
   localparam int IW = 5;

   logic                    clk_i = 1'b0;
   logic                    rst_ni;
   logic [N-1:0]            req_valid_i;
   logic [N-1:0]            req_ready_o;
   logic [N-1:0][31:0]      req_add_i;
   logic [N-1:0]            req_wen_i;
   logic [N-1:0][31:0]      req_data_i;
   logic [N-1:0][IW-1:0]    req_id_i;
   logic [N-1:0]            resp_valid_o;
   logic [N-1:0]            resp_ready_i;
   logic [N-1:0][31:0]      resp_data_o;
   logic [N-1:0][IW-1:0]    resp_id_o;
   logic                    busy_o;

   hwpe_ctrl_intf_periph #(.IdWidth(IW)) periph_if ();

   snax_hwpe_periph_arbiter #(.NumReq(N), .IdWidth(IW)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_add_i    (req_add_i),
      .req_wen_i    (req_wen_i),
      .req_data_i   (req_data_i),
      .req_id_i     (req_id_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o),
      .resp_id_o    (resp_id_o),
      .periph       (periph_if),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   // Model state: round-robin pointer and the payload each requester presents.
   int            m_ptr = 0;
   logic [31:0]   pa [N];
   logic          pw [N];
   logic [31:0]   pd [N];
   logic [IW-1:0] pi [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   function automatic int pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic drive_payload();
      for (int k = 0; k < N; k++) begin
         req_add_i[k]  = pa[k];
         req_wen_i[k]  = pw[k];
         req_data_i[k] = pd[k];
         req_id_i[k]   = pi[k];
      end
   endtask

   task automatic rand_payload();
      for (int k = 0; k < N; k++) begin
         pa[k] = $urandom;
         pw[k] = 1'($urandom);
         pd[k] = $urandom;
         pi[k] = IW'($urandom);
      end
   endtask

   // Change everything the requesters present; an accepted transaction must not notice.
   task automatic scramble();
      rand_payload();
      drive_payload();
      req_valid_i = N'($urandom);
   endtask

   task automatic run_txn(input logic [N-1:0] vld, input int gdly, input int rdly, input int hold,
                          input logic [31:0] rdata, input logic [IW-1:0] rid, output int got);
      int            g;
      logic [N-1:0]  e;
      logic [31:0]   ea, ed;
      logic          ew;
      logic [IW-1:0] ei;
      drive_payload();
      req_valid_i = vld;
      #1;
      g = pick(vld);
      e = '0;
      e[g] = 1'b1;
      got = -1;
      for (int k = 0; k < N; k++) if (req_ready_o[k]) got = k;
      chk("accept_ready", req_ready_o, e);
      chk("accept_busy", busy_o, 0);
      ea = pa[g]; ew = pw[g]; ed = pd[g]; ei = pi[g];
      cyc();
      for (int c = 0; c <= gdly; c++) begin
         scramble();
         periph_if.gnt     = (c == gdly);
         periph_if.r_valid = (c < gdly) ? 1'($urandom) : 1'b0;
         periph_if.r_data  = $urandom;
         #1;
         chk("issue_req", periph_if.req, 1);
         chk("issue_add", periph_if.add, ea);
         chk("issue_wen", periph_if.wen, ew);
         chk("issue_data", periph_if.data, ed);
         chk("issue_id", periph_if.id, ei);
         chk("issue_be", periph_if.be, ew ? 4'h0 : 4'hF);
         chk("issue_ready", req_ready_o, 0);
         chk("issue_resp", resp_valid_o, 0);
         chk("issue_busy", busy_o, 1);
         cyc();
      end
      periph_if.gnt = 1'b0;
      periph_if.r_valid = 1'b0;
      req_valid_i = '0;
      #1;
      if (!ew) begin
         chk("wr_done_busy", busy_o, 0);
         chk("wr_done_req", periph_if.req, 0);
         chk("wr_done_resp", resp_valid_o, 0);
         m_ptr = (g + 1) % N;
         return;
      end
      for (int c = 0; c <= rdly; c++) begin
         periph_if.r_valid = (c == rdly);
         periph_if.r_data  = (c == rdly) ? rdata : $urandom;
         periph_if.r_id    = (c == rdly) ? rid : IW'($urandom);
         req_valid_i = N'($urandom);
         #1;
         chk("wait_req", periph_if.req, 0);
         chk("wait_busy", busy_o, 1);
         chk("wait_resp", resp_valid_o, 0);
         chk("wait_ready", req_ready_o, 0);
         cyc();
      end
      for (int c = 0; c <= hold; c++) begin
         periph_if.r_valid = 1'($urandom);
         periph_if.r_data  = $urandom;
         periph_if.r_id    = IW'($urandom);
         resp_ready_i = N'($urandom);
         resp_ready_i[g] = (c == hold);
         req_valid_i = N'($urandom);
         #1;
         chk("resp_valid", resp_valid_o, e);
         chk("resp_data", resp_data_o[g], rdata);
         chk("resp_id", resp_id_o[g], rid);
         chk("resp_ready", req_ready_o, 0);
         cyc();
      end
      resp_ready_i = '0;
      periph_if.r_valid = 1'b0;
      req_valid_i = '0;
      #1;
      chk("rd_done_resp", resp_valid_o, 0);
      chk("rd_done_busy", busy_o, 0);
      m_ptr = (g + 1) % N;
   endtask

   initial begin
      int got;
      rst_ni = 1'b0;
      req_valid_i = '0;
      resp_ready_i = '0;
      periph_if.gnt = 1'b0;
      periph_if.r_valid = 1'b0;
      periph_if.r_data = '0;
      periph_if.r_id = '0;
      rand_payload();
      drive_payload();
      req_valid_i = '1;
      #2;
      chk("rst_ready", req_ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_req", periph_if.req, 0);
      chk("rst_be", periph_if.be, 0);
      chk("rst_resp", resp_valid_o, 0);
      req_valid_i = '0;
      @(negedge clk_i);
      cyc();
      rst_ni = 1'b1;
      cyc();

      // Spurious r_valid while idle.
      periph_if.r_valid = 1'b1;
      cyc();
      periph_if.r_valid = 1'b0;
      #1;
      chk("spur_idle_resp", resp_valid_o, 0);
      chk("spur_idle_busy", busy_o, 0);

      // Single write from requester 0.
      pa[0] = 32'h8; pw[0] = 1'b0; pd[0] = 32'hDEADBEEF; pi[0] = 5'd1;
      run_txn(3'b001, 0, 0, 0, 32'h0, '0, got);
      chk("wr_winner", got, 0);

      // Single read from requester 1, response held 3 cycles.
      pa[1] = 32'h10; pw[1] = 1'b1; pd[1] = 32'h0; pi[1] = 5'd2;
      run_txn(3'b010, 0, 0, 3, 32'h1234, 5'd3, got);
      chk("rd_winner", got, 1);

      // Contention between 0 and 1 with immediate grants: strict alternation.
      for (int t = 0; t < 4; t++) begin
         rand_payload();
         pw[0] = 1'b0; pw[1] = 1'b0;
         run_txn(3'b011, 0, 0, 0, '0, '0, got);
         chk("rr_pair", got, t % 2);
      end

      // All requesters valid: each granted once per N transactions.
      begin
         int seen [N];
         for (int k = 0; k < N; k++) seen[k] = 0;
         for (int t = 0; t < 2 * N; t++) begin
            rand_payload();
            run_txn('1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom, IW'($urandom), got);
            if (got >= 0) seen[got]++;
         end
         for (int k = 0; k < N; k++) chk("fair_count", seen[k], 2);
      end

      // Delayed grant on a write with spurious r_valid during ISSUE.
      rand_payload();
      pw[0] = 1'b0; pw[1] = 1'b0; pw[2] = 1'b0;
      run_txn('1, 5, 0, 0, '0, '0, got);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] v;
         rand_payload();
         v = N'($urandom_range(1, (1 << N) - 1));
         run_txn(v, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom, IW'($urandom), got);
      end

      // Reset during WAIT_R, then a late r_valid.
      pa[1] = 32'h40; pw[1] = 1'b1; pd[1] = 32'h0; pi[1] = 5'd7;
      drive_payload();
      req_valid_i = 3'b010;
      cyc();
      req_valid_i = '0;
      periph_if.gnt = 1'b1;
      cyc();
      periph_if.gnt = 1'b0;
      #1;
      chk("wr_busy_pre_rst", busy_o, 1);
      rst_ni = 1'b0;
      req_valid_i = '1;
      #1;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_ready", req_ready_o, 0);
      chk("mid_rst_req", periph_if.req, 0);
      chk("mid_rst_add", periph_if.add, 0);
      chk("mid_rst_wen", periph_if.wen, 0);
      chk("mid_rst_data", periph_if.data, 0);
      chk("mid_rst_id", periph_if.id, 0);
      chk("mid_rst_resp", resp_valid_o, 0);
      chk("mid_rst_rdata", resp_data_o, 0);
      chk("mid_rst_rid", resp_id_o, 0);
      req_valid_i = '0;
      cyc();
      rst_ni = 1'b1;
      periph_if.r_valid = 1'b1;
      periph_if.r_data = 32'hCAFE;
      cyc();
      periph_if.r_valid = 1'b0;
      #1;
      chk("late_rv_resp", resp_valid_o, 0);
      chk("late_rv_busy", busy_o, 0);
      m_ptr = 0;
      rand_payload();
      run_txn('1, 0, 0, 0, $urandom, IW'($urandom), got);
      chk("post_rst_winner", got, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/snax_hwpe_periph_arbiter.md
SNAX_HWPE_PERIPH_ARBITER -- requirements
Module: snax_hwpe_periph_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requester ports (range 2..8).
REQ-002 SHALL have parameter IdWidth, default 5, width of transaction ID.
REQ-003 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid_i / req_ready_o  input/output  NumReq  per-requester request handshake.
REQ-006 SHALL have ports req_add_i [NumReq][32], req_wen_i [NumReq] (1=read, 0=write), req_data_i [NumReq][32], req_id_i [NumReq][IdWidth]  input  per-requester payload.
REQ-007 SHALL have ports resp_valid_o  output  NumReq, resp_ready_i  input  NumReq, resp_data_o  output  [NumReq][32], resp_id_o  output  [NumReq][IdWidth]  per-requester read response.
REQ-008 SHALL have port periph  hwpe_ctrl_intf_periph.master  shared 32-bit HWPE register port (req, gnt, add, wen, be, data, id, r_valid, r_data, r_id).
REQ-009 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM with states IDLE, ISSUE, WAIT_R, RESP; one transaction outstanding at a time.
REQ-011 IDLE: if any req_valid_i, SHALL select winner g as first asserted index at or after round-robin pointer ptr (wrapping NumReq-1 -> 0), assert req_ready_o[g] combinationally in that cycle only, register payload and g, go to ISSUE.
REQ-012 req_ready_o SHALL be 0 for all non-winners and in all states other than IDLE.
REQ-013 ISSUE: periph.req SHALL be 1 from registers (no combinational path from req_*_i); add, wen, data, id held stable until periph.gnt.
REQ-014 periph.be SHALL be 4'hF for writes, 4'h0 for reads.
REQ-015 ISSUE with periph.gnt=1 and write: SHALL deassert periph.req next cycle, go to IDLE, set ptr = (g+1) mod NumReq.
REQ-016 ISSUE with periph.gnt=1 and read: SHALL deassert periph.req next cycle, go to WAIT_R.
REQ-017 WAIT_R: on periph.r_valid SHALL capture r_data, r_id into resp_data_o[g], resp_id_o[g], assert resp_valid_o[g] next cycle, go to RESP.
REQ-018 periph.r_valid outside WAIT_R SHALL be ignored (no state or output change).
REQ-019 RESP: resp_valid_o[g] and data SHALL hold until resp_ready_i[g]=1; then go to IDLE, set ptr = (g+1) mod NumReq, clear resp_valid_o[g] next cycle.
REQ-020 Only resp_valid_o[g] of current owner SHALL ever be 1; others 0.
REQ-021 Latency: write accepted cycle T -> periph.req at T+1; read with gnt at T+1 and r_valid at T+2 -> resp_valid_o at T+3.
REQ-022 Minimum back-to-back spacing SHALL be one IDLE cycle between transactions (new accept in IDLE only).
REQ-023 Requester deasserting req_valid_i while not accepted SHALL lose no state; accepted payload is never re-sampled.
REQ-024 Fairness: with all requesters continuously valid, each SHALL be granted exactly once per NumReq consecutive transactions.

Reset
REQ-025 On rst_ni=0 SHALL immediately force: state IDLE, ptr 0, periph.req/add/wen/be/data/id 0, req_ready_o 0, resp_valid_o 0, resp_data_o 0, resp_id_o 0, busy_o 0.
REQ-026 Reset mid-transaction (ISSUE, WAIT_R, RESP) SHALL abandon it; a late periph.r_valid after release SHALL be ignored per REQ-018.

Verification
REQ-027 Single write: req 0 valid, add=0x8, data=0xDEADBEEF, wen=0 -> ready[0] same cycle; next cycle periph.req=1, be=0xF, add=0x8; gnt -> back to IDLE, busy_o=0.
REQ-028 Single read: req 1, add=0x10, wen=1; gnt next cycle; r_valid with r_data=0x1234, r_id=3 -> resp_valid_o[1]=1, resp_data_o[1]=0x1234, resp_id_o[1]=3, held while resp_ready_i[1]=0 for 3 cycles.
REQ-029 Contention: NumReq=2, both valid continuously with writes, gnt always 1 -> grant order 0,1,0,1; ready never high for both in one cycle.
REQ-030 Delayed gnt: gnt held low 5 cycles in ISSUE -> periph.add/data/wen stable all 5 cycles; no new ready asserted.
REQ-031 Spurious r_valid in IDLE and during a write's ISSUE -> no resp_valid_o on any port.
REQ-032 Reset asserted in WAIT_R, r_valid arrives after release -> all outputs 0, no response, next request arbitrated from ptr 0.
